// File: rtl/core_ctrl_ldst_pop_if.sv
// core_ctrl_ldst_pop_if: pending register list in, pop results out
interface core_ctrl_ldst_pop_if;
    logic [15:0] regs;
    logic        valid;
    logic [3:0]  pop_lower;
    logic [15:0] next_lower;
    logic [3:0]  pop_upper;
    logic [15:0] next_upper;
    modport master (output regs, input valid, pop_lower, next_lower, pop_upper, next_upper);
    modport slave (input regs, output valid, pop_lower, next_lower, pop_upper, next_upper);
endinterface

// File: rtl/core_ctrl_ldst_pop.sv
// core_ctrl_ldst_pop: lowest/highest pending register pop for LDM/STM sequencing
module core_ctrl_ldst_pop (
    input  logic                       clk,
    input  logic                       rst,
    core_ctrl_ldst_pop_if.slave        pop_io
);
    logic [3:0] lo;
    logic [3:0] hi;
    logic       unused;
    // clk/rst exist only for a uniform controller interface; nothing is clocked
    assign unused = ^{clk, rst};
    // LSB-first priority encoder: the last hit while scanning down is the lowest set bit
    always_comb begin
        lo = 4'd0;
        for (int i = 15; i >= 0; i--)
            if (pop_io.regs[i]) lo = i[3:0];
    end
    // MSB-first priority encoder: the last hit while scanning up is the highest set bit
    always_comb begin
        hi = 4'd0;
        for (int i = 0; i < 16; i++)
            if (pop_io.regs[i]) hi = i[3:0];
    end
    // an empty list leaves both indices at 0 and clearing bit 0 of zero stays zero
    assign pop_io.valid      = |pop_io.regs;
    assign pop_io.pop_lower  = lo;
    assign pop_io.pop_upper  = hi;
    assign pop_io.next_lower = pop_io.regs & ~(16'h0001 << lo);
    assign pop_io.next_upper = pop_io.regs & ~(16'h0001 << hi);
endmodule

// File: tb/tb_core_ctrl_ldst_pop.sv
// tb_core_ctrl_ldst_pop: directed table, pop-chain sequences and exhaustive sweep
module tb_core_ctrl_ldst_pop;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    core_ctrl_ldst_pop_if bus ();
    core_ctrl_ldst_pop dut (.clk(clk), .rst(rst), .pop_io(bus.slave));

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] regs;
        logic        valid;
        logic [3:0]  lo;
        logic [15:0] nl;
        logic [3:0]  hi;
        logic [15:0] nu;
    } vec_t;

    vec_t tbl [8];

    function automatic vec_t model(input logic [15:0] r);
        vec_t m;
        bit   found;
        m.regs  = r;
        m.valid = (r != 16'h0);
        m.lo = 4'd0;
        m.hi = 4'd0;
        found = 0;
        for (int i = 0; i < 16; i++)
            if (!found && r[i]) begin m.lo = 4'(i); found = 1; end
        found = 0;
        for (int i = 15; i >= 0; i--)
            if (!found && r[i]) begin m.hi = 4'(i); found = 1; end
        m.nl = r & (r - 16'h1);
        m.nu = (r == 16'h0) ? 16'h0 : (r ^ (16'h1 << m.hi));
        return m;
    endfunction

    task automatic check(input string name, input vec_t e);
        n_cmp++;
        if (bus.valid !== e.valid || bus.pop_lower !== e.lo || bus.next_lower !== e.nl ||
            bus.pop_upper !== e.hi || bus.next_upper !== e.nu) begin
            n_bad++;
            $display("FAIL %s regs=%h got v=%b lo=%0d nl=%h hi=%0d nu=%h want v=%b lo=%0d nl=%h hi=%0d nu=%h",
                     name, e.regs, bus.valid, bus.pop_lower, bus.next_lower, bus.pop_upper, bus.next_upper,
                     e.valid, e.lo, e.nl, e.hi, e.nu);
        end
    endtask

    task automatic chain(input string name, input bit up, input logic [3:0] exp [5]);
        logic [15:0] r;
        r = 16'h40F0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            bus.regs = r;
            #1;
            n_cmp++;
            if (bus.valid !== 1'b1 || (up ? bus.pop_upper : bus.pop_lower) !== exp[k]) begin
                n_bad++;
                $display("FAIL %s step %0d got v=%b pop=%0d want v=1 pop=%0d", name, k, bus.valid,
                         up ? bus.pop_upper : bus.pop_lower, exp[k]);
            end
            r = up ? bus.next_upper : bus.next_lower;
        end
        @(negedge clk);
        bus.regs = r;
        #1;
        n_cmp++;
        if (bus.valid !== 1'b0 || r !== 16'h0) begin
            n_bad++;
            $display("FAIL %s end got v=%b regs=%h want v=0 regs=0000", name, bus.valid, r);
        end
    endtask

    initial begin
        logic [3:0] asc [5];
        logic [3:0] desc [5];
        asc  = '{4'd4, 4'd5, 4'd6, 4'd7, 4'd14};
        desc = '{4'd14, 4'd7, 4'd6, 4'd5, 4'd4};
        tbl[0] = '{16'h0000, 1'b0, 4'd0,  16'h0000, 4'd0,  16'h0000};
        tbl[1] = '{16'h8001, 1'b1, 4'd0,  16'h8000, 4'd15, 16'h0001};
        tbl[2] = '{16'h0010, 1'b1, 4'd4,  16'h0000, 4'd4,  16'h0000};
        tbl[3] = '{16'hFFFF, 1'b1, 4'd0,  16'hFFFE, 4'd15, 16'h7FFF};
        tbl[4] = '{16'h40F0, 1'b1, 4'd4,  16'h40E0, 4'd14, 16'h00F0};
        tbl[5] = '{16'h0006, 1'b1, 4'd1,  16'h0004, 4'd2,  16'h0002};
        tbl[6] = '{16'h8000, 1'b1, 4'd15, 16'h0000, 4'd15, 16'h0000};
        tbl[7] = '{16'h1234, 1'b1, 4'd2,  16'h1230, 4'd12, 16'h0234};

        bus.regs = 16'h0000;
        @(negedge clk);
        #1;
        check("reset_empty", tbl[0]);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.regs = tbl[i].regs;
            #1;
            check($sformatf("vec%0d", i), tbl[i]);
        end

        chain("chain_lower", 1'b0, asc);
        chain("chain_upper", 1'b1, desc);

        for (int v = 0; v < 65536; v++) begin
            @(negedge clk);
            if (v == 16'h8000) rst = 1'b1;
            if (v == 16'h8100) rst = 1'b0;
            bus.regs = 16'(v);
            #1;
            check("sweep", model(16'(v)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
